image_binarize_packer: RTL
==========================

# image_binarize_packer

Upstream feeder for the classifier IP. It accepts a stream of 8-bit grayscale pixels, one pixel per beat, and thresholds each pixel to one bit. It packs the bits LSB-first into 128-bit words and emits exactly 8 words per image. The output is the stream the classifier consumes on `tdata`/`tvalid`/`tkeep`/`tlast`. Bit p of the image appears at word p/128, bit p%128, which matches the classifier's image memory layout.

## Interface
- `HEIGHT`, 28, image rows.
- `WIDTH`, 28, image columns; NPIX = HEIGHT*WIDTH, which must be ≤ 1024.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `threshold` input 8: pixel binarization threshold; software holds it stable for a whole image.
- `s_tdata` input 8: grayscale pixel.
- `s_tvalid` input 1: pixel valid.
- `s_tready` output 1: pixel accepted when `s_tvalid && s_tready`.
- `s_tlast` input 1: last pixel of the image.
- `m_tdata` output 128: packed word to the classifier.
- `m_tvalid` output 1: word valid.
- `m_tready` input 1: classifier ready.
- `m_tkeep` output 16: constant 16'hFFFF.
- `m_tlast` output 1: high on word 7 of each image only.
- `frame_err` output 1: sticky flag for pixel count/tlast mismatch; cleared only by reset.
- `img_count` output 16: number of images fully emitted; wraps at 2^16.

## Operation
- Binarization: bit = (`s_tdata` >= `threshold`), unsigned compare. A pixel equal to the threshold gives 1.
- Internal registers:
  - assembly word `asm[127:0]` with flag `asm_full`;
  - bit pointer `bp[6:0]`;
  - word index `wi[2:0]`;
  - pixel counter `pix_cnt` (10 bits);
  - output register driving `m_tdata`, `m_tvalid`, `m_tlast`.
- Accepted pixel: write bit into `asm[bp]`, then increment `bp` and `pix_cnt`.
- Word completion: the word is complete when the accepted pixel has `bp==127`, or when the pixel ends the image (tlast, or `pix_cnt==NPIX-1`). On completion, set `asm_full`.
- Transfer: when `asm_full && (!m_tvalid || m_tready)`, load the output register with `asm`. On that edge:
  - `m_tlast` = (`wi==7`);
  - clear `asm` to zero and `asm_full`;
  - reset `bp` to 0;
  - increment `wi` (mod 8).
- Image end: after the transfer with `wi==7`, increment `img_count` and reset `pix_cnt` to 0.
- FSM, FILL state:
  - `s_tready` = !`asm_full`.
  - Image end by `s_tlast` with `pix_cnt < NPIX-1` sets `frame_err` → PAD.
  - Image end by `pix_cnt==NPIX-1`: if `s_tlast` is high → PAD, and the next state is FILL. If `s_tlast` is low, set `frame_err` → PAD, and the next state is DROP.
- FSM, PAD state:
  - `s_tready`=0.
  - While `wi` has not yet wrapped, reassert `asm_full` with a zero word after each transfer, so the remaining words up to word 7 are zero.
  - After word 7 is transferred, go to the recorded next state (FILL or DROP).
- FSM, DROP state:
  - `s_tready`=1.
  - Discard pixels until one with `s_tlast` is accepted → FILL.
- An image that ends exactly at word 7 (bit 127 of word 7, possible only when NPIX=1024) needs no padding; PAD exits on that transfer.

## Timing
- Reset values: `s_tready`=0 while `rst_n` is low, then 1 (FILL state, `asm_full`=0); `m_tvalid`=0; `m_tdata`=0; `m_tlast`=0; `frame_err`=0; `img_count`=0; state FILL; `bp`, `wi`, `pix_cnt`=0.
- Latency: a pixel completing a word is accepted at edge N, `asm_full`=1 after N, and `m_tvalid`=1 after N+1 if the output register is free. One `s_tready` bubble per word, so a full 128-bit word takes 129 cycles at best.
- Output hold: `m_tdata`, `m_tlast` and `m_tvalid` stay stable while `m_tvalid && !m_tready`.
- Padding words are emitted back-to-back at one per two cycles under `m_tready`=1.
- Transfer and completion in the same cycle cannot occur, because `s_tready`=0 while `asm_full` is set.
- `rst_n` asserted mid-image: everything clears immediately. The partial image is lost and `img_count` is unchanged.

## Test plan
- Test 1, full image:
  - Stimulus: `threshold`=128, 784 pixels of 200, `s_tlast` on pixel 784, `m_tready`=1.
  - Response: 8 beats. Words 0–5 all ones; word 6 = 128'h...0000FFFF (low 16 bits set); word 7 = 0. `m_tlast` on beat 7 only, `img_count`=1, `frame_err`=0.
- Test 2, threshold boundary:
  - Stimulus: pixel p value = (p%2 ? 128 : 127), `threshold`=128.
  - Response: words 0–5 = 128'hAAAA...AAAA.
- Test 3, early tlast:
  - Stimulus: `s_tlast` on pixel 130.
  - Response: word 0 all ones, word 1 = 128'h3, words 2–7 zero, 8 beats, `frame_err`=1.
- Test 4, missing tlast:
  - Stimulus: 800 pixels with `s_tlast` on pixel 800.
  - Response: 8 beats after pixel 784, pixels 785–800 dropped with `s_tready`=1, `frame_err`=1. The next image is packed correctly from its pixel 0.
- Test 5, backpressure:
  - Stimulus: `m_tready` held low for 300 cycles from the start of an image.
  - Response: `s_tready` stalls after 256 pixels (one word in the output register, one in `asm`). `m_tdata` is stable throughout. After release, all 8 words are identical to Test 1.
- Test 6, reset mid-image:
  - Stimulus: `rst_n` pulsed low after 400 pixels.
  - Response: all outputs return to reset values asynchronously, `img_count`=0. A following full image matches Test 1.

Source files
------------

// File: rtl/image_binarize_packer.sv
// image_binarize_packer
// Thresholds an 8-bit grayscale pixel stream to one bit per pixel and packs
// the bits LSB-first into 128-bit words, exactly 8 words per image. Bit p of
// the image lands in word p/128, bit p%128. Short images are zero-padded up
// to word 7; over-long images are truncated and the excess pixels dropped up
// to the next tlast. Any pixel count / tlast disagreement raises a sticky
// frame_err. HEIGHT*WIDTH must not exceed 1024 (10-bit pixel counter).
module image_binarize_packer #(
    parameter int HEIGHT = 28,
    parameter int WIDTH  = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   threshold,
    input  logic [7:0]   s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         s_tlast,
    output logic [127:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [15:0]  m_tkeep,
    output logic         m_tlast,
    output logic         frame_err,
    output logic [15:0]  img_count
);

    localparam int         NPIX     = HEIGHT * WIDTH;
    localparam logic [9:0] LAST_PIX = 10'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Pixel binarization: a pixel equal to the threshold maps to 1.
    function automatic logic pix_bit(input logic [7:0] pix, input logic [7:0] thr);
        return (pix >= thr);
    endfunction

    // Registered state
    state_t         state_r;
    state_t         after_pad_r;   // state to enter once word 7 has left
    logic [127:0]   asm_r;
    logic           asm_full_r;
    logic [6:0]     bp_r;
    logic [2:0]     wi_r;
    logic [9:0]     pix_cnt_r;
    logic           s_tready_r;
    logic [127:0]   m_tdata_r;
    logic           m_tvalid_r;
    logic           m_tlast_r;
    logic           frame_err_r;
    logic [15:0]    img_count_r;

    // Next-state values
    state_t         state_nx_s;
    state_t         after_pad_nx_s;
    logic [127:0]   asm_nx_s;
    logic           asm_full_nx_s;
    logic [6:0]     bp_nx_s;
    logic [2:0]     wi_nx_s;
    logic [9:0]     pix_cnt_nx_s;
    logic           s_tready_nx_s;
    logic [127:0]   m_tdata_nx_s;
    logic           m_tvalid_nx_s;
    logic           m_tlast_nx_s;
    logic           frame_err_nx_s;
    logic [15:0]    img_count_nx_s;

    logic           accept_s;
    logic           xfer_s;
    logic           img_end_s;

    assign accept_s  = s_tvalid && s_tready_r;
    assign xfer_s    = asm_full_r && (!m_tvalid_r || m_tready);
    assign img_end_s = s_tlast || (pix_cnt_r == LAST_PIX);

    // Next-state logic: output-register transfer, then per-state packing/padding/dropping.
    always_comb begin
        state_nx_s     = state_r;
        after_pad_nx_s = after_pad_r;
        asm_nx_s       = asm_r;
        asm_full_nx_s  = asm_full_r;
        bp_nx_s        = bp_r;
        wi_nx_s        = wi_r;
        pix_cnt_nx_s   = pix_cnt_r;
        m_tdata_nx_s   = m_tdata_r;
        m_tvalid_nx_s  = m_tvalid_r;
        m_tlast_nx_s   = m_tlast_r;
        frame_err_nx_s = frame_err_r;
        img_count_nx_s = img_count_r;
        s_tready_nx_s  = 1'b0;

        // Move a completed assembly word into the output register.
        if (xfer_s) begin
            m_tdata_nx_s  = asm_r;
            m_tvalid_nx_s = 1'b1;
            m_tlast_nx_s  = (wi_r == 3'd7);
            asm_nx_s      = 128'd0;
            asm_full_nx_s = 1'b0;
            bp_nx_s       = 7'd0;
            wi_nx_s       = wi_r + 3'd1;
            if (wi_r == 3'd7) begin
                img_count_nx_s = img_count_r + 16'd1;
                pix_cnt_nx_s   = 10'd0;
            end else begin
                img_count_nx_s = img_count_r;
            end
        end else if (m_tready) begin
            m_tvalid_nx_s = 1'b0;
        end else begin
            m_tvalid_nx_s = m_tvalid_r;
        end

        case (state_r)
            ST_FILL: begin
                // accept_s implies asm_full_r==0, so no transfer this cycle.
                if (accept_s) begin
                    asm_nx_s[bp_r] = pix_bit(s_tdata, threshold);
                    bp_nx_s        = bp_r + 7'd1;
                    pix_cnt_nx_s   = pix_cnt_r + 10'd1;
                    if ((bp_r == 7'd127) || img_end_s) begin
                        asm_full_nx_s = 1'b1;
                    end else begin
                        asm_full_nx_s = 1'b0;
                    end
                    if (img_end_s) begin
                        state_nx_s = ST_PAD;
                        if (pix_cnt_r == LAST_PIX) begin
                            if (s_tlast) begin
                                after_pad_nx_s = ST_FILL;
                            end else begin
                                after_pad_nx_s = ST_DROP;
                                frame_err_nx_s = 1'b1;
                            end
                        end else begin
                            after_pad_nx_s = ST_FILL;
                            frame_err_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_FILL;
                    end
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_PAD: begin
                if (xfer_s) begin
                    if (wi_r == 3'd7) begin
                        state_nx_s = after_pad_r;
                    end else begin
                        state_nx_s = ST_PAD;
                    end
                end else if (!asm_full_r) begin
                    // Queue the next zero word (asm was cleared by the transfer).
                    asm_full_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_PAD;
                end
            end
            ST_DROP: begin
                if (accept_s && s_tlast) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            default: begin
                state_nx_s = ST_FILL;
            end
        endcase

        case (state_nx_s)
            ST_FILL: s_tready_nx_s = !asm_full_nx_s;
            ST_DROP: s_tready_nx_s = 1'b1;
            default: s_tready_nx_s = 1'b0;
        endcase
    end

    // State and output registers; everything clears immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            after_pad_r <= ST_FILL;
            asm_r       <= 128'd0;
            asm_full_r  <= 1'b0;
            bp_r        <= 7'd0;
            wi_r        <= 3'd0;
            pix_cnt_r   <= 10'd0;
            s_tready_r  <= 1'b0;
            m_tdata_r   <= 128'd0;
            m_tvalid_r  <= 1'b0;
            m_tlast_r   <= 1'b0;
            frame_err_r <= 1'b0;
            img_count_r <= 16'd0;
        end else begin
            state_r     <= state_nx_s;
            after_pad_r <= after_pad_nx_s;
            asm_r       <= asm_nx_s;
            asm_full_r  <= asm_full_nx_s;
            bp_r        <= bp_nx_s;
            wi_r        <= wi_nx_s;
            pix_cnt_r   <= pix_cnt_nx_s;
            s_tready_r  <= s_tready_nx_s;
            m_tdata_r   <= m_tdata_nx_s;
            m_tvalid_r  <= m_tvalid_nx_s;
            m_tlast_r   <= m_tlast_nx_s;
            frame_err_r <= frame_err_nx_s;
            img_count_r <= img_count_nx_s;
        end
    end

    assign s_tready  = s_tready_r;
    assign m_tdata   = m_tdata_r;
    assign m_tvalid  = m_tvalid_r;
    assign m_tlast   = m_tlast_r;
    assign m_tkeep   = 16'hFFFF;
    assign frame_err = frame_err_r;
    assign img_count = img_count_r;

endmodule
